// File: rtl/button_counter_db.sv
// Two-button up/down counter with synchronizers, debouncers and an auto-count mode.
// Manual mode steps on each debounced press; auto mode steps on a periodic tick.
module button_counter_db #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DB_CYCLES   = 120000,
    parameter int unsigned TICK_CYCLES = 6000000
) (
    input  logic             clk_12M,
    input  logic             rst,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    input  logic             mode,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES);
    localparam int unsigned TICK_W = $clog2(TICK_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    // Auto-mode run/dir pair, kept across mode changes
    typedef enum logic [1:0] {
        S_RUN_UP  = 2'b00,
        S_RUN_DN  = 2'b01,
        S_HOLD_UP = 2'b10,
        S_HOLD_DN = 2'b11
    } auto_state_t;

    // Index 0 = up button, index 1 = down button
    logic [1:0]      pad_act;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      stable_d;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    logic [TICK_W-1:0] tick_cnt;

    auto_state_t state;
    auto_state_t state_nxt;
    logic        up_p;
    logic        dn_p;
    logic        run_c;
    logic        dir_c;
    logic        inc_c;
    logic        dec_c;

    assign pad_act = ~{btn_dn_n, btn_up_n};
    assign up_p    = press[0];
    assign dn_p    = press[1];

    // Synchronize, debounce and detect the released->pressed edge of each button
    always_ff @(posedge clk_12M) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= pad_act;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Tick period restarts from zero whenever auto mode is left
    always_ff @(posedge clk_12M) begin
        if (rst || !mode) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= (tick_cnt == TICK_LAST);
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk_12M) begin
        if (rst) begin
            state <= S_RUN_UP;
        end else begin
            state <= state_nxt;
        end
    end

    // Steps are decided from the pre-toggle run/dir values
    always_comb begin
        state_nxt = state;
        run_c     = (state == S_RUN_UP) || (state == S_RUN_DN);
        dir_c     = (state == S_RUN_DN) || (state == S_HOLD_DN);
        inc_c     = 1'b0;
        dec_c     = 1'b0;
        if (mode) begin
            if (tick && run_c) begin
                inc_c = !dir_c;
                dec_c = dir_c;
            end
            case ({run_c ^ up_p, dir_c ^ dn_p})
                2'b10:   state_nxt = S_RUN_UP;
                2'b11:   state_nxt = S_RUN_DN;
                2'b00:   state_nxt = S_HOLD_UP;
                default: state_nxt = S_HOLD_DN;
            endcase
        end else begin
            inc_c = up_p && !dn_p;
            dec_c = dn_p && !up_p;
        end
    end

    always_ff @(posedge clk_12M) begin
        if (rst) begin
            led  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= (inc_c && (led == '1)) || (dec_c && (led == '0));
            if (inc_c) begin
                led <= led + WIDTH'(1);
            end else if (dec_c) begin
                led <= led - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_counter_db.sv
// Bench for button_counter_db: directed scenarios plus random pad/mode/reset
// activity, all compared each cycle against a timeline-based reference model.
module tb_button_counter_db;

    localparam int W   = 4;
    localparam int DB  = 4;
    localparam int TK  = 8;
    localparam int MOD = 1 << W;

    logic         clk_12M = 1'b0;
    logic         rst     = 1'b1;
    logic         btn_up_n = 1'b1;
    logic         btn_dn_n = 1'b1;
    logic         mode    = 1'b0;
    logic [W-1:0] led;
    logic         tick;
    logic         wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    button_counter_db #(
        .WIDTH      (W),
        .DB_CYCLES  (DB),
        .TICK_CYCLES(TK)
    ) dut (
        .clk_12M (clk_12M),
        .rst     (rst),
        .btn_up_n(btn_up_n),
        .btn_dn_n(btn_dn_n),
        .mode    (mode),
        .led     (led),
        .tick    (tick),
        .wrap    (wrap)
    );

    always #5 clk_12M = ~clk_12M;

    // Reference model state: pad delay line, streak start edge per button,
    // pulse timeline and counter value.
    int m_edge      = 0;
    bit m_pipe [2][2];
    bit m_stab [2];
    int m_streak [2] = '{-1, -1};
    bit m_rise [2];
    bit m_up_p  = 1'b0;
    bit m_dn_p  = 1'b0;
    int m_age   = 0;
    bit m_tick  = 1'b0;
    bit m_wrap  = 1'b0;
    bit m_run   = 1'b1;
    bit m_dir   = 1'b0;
    int m_led   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit pad [2];
        bit s2;
        int delta;
        int nxt;
        m_edge++;
        pad[0] = !btn_up_n;
        pad[1] = !btn_dn_n;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_pipe[b][0] = 1'b0;
                m_pipe[b][1] = 1'b0;
                m_stab[b]    = 1'b0;
                m_streak[b]  = -1;
                m_rise[b]    = 1'b0;
            end
            m_up_p = 1'b0; m_dn_p = 1'b0;
            m_age  = 0;    m_tick = 1'b0;
            m_wrap = 1'b0; m_led  = 0;
            m_run  = 1'b1; m_dir  = 1'b0;
            return;
        end
        // counter reacts to pulses that were visible before this edge
        delta = 0;
        if (!mode) begin
            if (m_up_p && !m_dn_p) delta = 1;
            else if (m_dn_p && !m_up_p) delta = -1;
        end else begin
            if (m_tick && m_run) delta = m_dir ? -1 : 1;
            m_run ^= m_up_p;
            m_dir ^= m_dn_p;
        end
        nxt    = m_led + delta;
        m_wrap = (nxt < 0) || (nxt >= MOD);
        m_led  = (nxt + MOD) % MOD;
        if (mode) begin
            m_age++;
            m_tick = (m_age % TK) == 0;
        end else begin
            m_age  = 0;
            m_tick = 1'b0;
        end
        m_up_p = m_rise[0];
        m_dn_p = m_rise[1];
        for (int b = 0; b < 2; b++) begin
            s2        = m_pipe[b][0];
            m_rise[b] = 1'b0;
            if (s2 == m_stab[b]) begin
                m_streak[b] = -1;
            end else begin
                if (m_streak[b] < 0) m_streak[b] = m_edge;
                if (m_edge - m_streak[b] + 1 >= DB) begin
                    m_rise[b]   = s2;
                    m_stab[b]   = s2;
                    m_streak[b] = -1;
                end
            end
            m_pipe[b][0] = m_pipe[b][1];
            m_pipe[b][1] = pad[b];
        end
    endtask

    task automatic step();
        @(posedge clk_12M);
        model_edge();
        @(negedge clk_12M);
        cyc++;
        check("led",  32'(led),  32'(m_led));
        check("tick", 32'(tick), 32'(m_tick));
        check("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_led",  32'(led),  0);
        check("rst_tick", 32'(tick), 0);
        check("rst_wrap", 32'(wrap), 0);
    endtask

    // Press one or both pads; the counter must move on edge DB+4 after the press
    task automatic tap(input bit up, input bit dn, input int exp_led, input int exp_wrap,
                       input string tag);
        btn_up_n = !up;
        btn_dn_n = !dn;
        repeat (DB + 3) step();
        step();
        check({tag, "_led"},  32'(led),  32'(exp_led));
        check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
        step();
        check({tag, "_wrap_1cyc"}, 32'(wrap), 0);
        repeat (4) step();
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (DB + 6) step();
    endtask

    task automatic hold_press(input bit up);
        if (up) btn_up_n = 1'b0; else btn_dn_n = 1'b0;
        repeat (DB + 6) step();
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (DB + 6) step();
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 3 * TK && tick !== 1'b1; i++) step();
        check("tick_seen", 32'(tick), 1);
    endtask

    initial begin
        int v;
        do_reset();

        // held up press: single step at edge DB+4, nothing more while held
        btn_up_n = 1'b0;
        repeat (DB + 3) step();
        check("up_before_edge8", 32'(led), 0);
        step();
        check("up_edge8", 32'(led), 1);
        repeat (10) step();
        check("up_held", 32'(led), 1);
        btn_up_n = 1'b1;
        repeat (DB + 6) step();

        // short glitch is ignored
        btn_up_n = 1'b0;
        repeat (DB - 1) step();
        btn_up_n = 1'b1;
        repeat (12) step();
        check("glitch_led", 32'(led), 1);

        tap(1'b0, 1'b1, 0,  0, "dn_1to0");
        tap(1'b0, 1'b1, 15, 1, "dn_wrap");
        tap(1'b1, 1'b0, 0,  1, "up_wrap");
        tap(1'b1, 1'b0, 1,  0, "up_0to1");
        tap(1'b1, 1'b1, 1,  0, "both");

        // button held across reset presses again only after a fresh debounce
        btn_up_n = 1'b0;
        repeat (20) step();
        check("held_pre_rst", 32'(led), 2);
        do_reset();
        repeat (DB + 3) step();
        check("held_rst_e7", 32'(led), 0);
        step();
        check("held_rst_e8", 32'(led), 1);
        btn_up_n = 1'b1;
        repeat (DB + 6) step();

        // auto mode from reset: tick every TK cycles, led follows one cycle later
        mode = 1'b1;
        do_reset();
        step();
        for (int i = 1; i <= 3; i++) begin
            repeat (TK - 1) step();
            check("auto_tick", 32'(tick), 1);
            check("auto_led_at_tick", 32'(led), 32'(i - 1));
            step();
            check("auto_tick_1cyc", 32'(tick), 0);
            check("auto_led_step", 32'(led), 32'(i));
        end
        hold_press(1'b0);
        wait_tick();
        v = int'(led);
        step();
        check("auto_down", 32'(led), 32'((v + MOD - 1) % MOD));
        hold_press(1'b1);
        wait_tick();
        v = int'(led);
        step();
        check("auto_frozen", 32'(led), 32'(v));
        step();
        wait_tick();
        step();
        check("auto_frozen2", 32'(led), 32'(v));

        // resume counting up, reset mid-count at led=9
        hold_press(1'b1);
        hold_press(1'b0);
        for (int i = 0; i < 400 && led != W'(9); i++) step();
        check("reach9", 32'(led), 9);
        do_reset();
        repeat (TK - 1) step();
        check("rst_no_early_tick", 32'(tick), 0);
        step();
        check("rst_first_tick", 32'(tick), 1);
        step();
        check("rst_first_step", 32'(led), 1);

        // random pads, mode flips and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) btn_up_n = ~btn_up_n;
            if ($urandom_range(0, 5) == 0) btn_dn_n = ~btn_dn_n;
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/button_counter_db.md
BUTTON_COUNTER_DB -- requirements
Module: button_counter_db

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter and led width in bits, legal range 1..32.
REQ-002 SHALL have parameter DB_CYCLES, default 120000: debounce hold time in clk_12M cycles (10 ms), legal range at least 2.
REQ-003 SHALL have parameter TICK_CYCLES, default 6000000: auto-count period in clk_12M cycles (0.5 s), legal range at least 2.
REQ-004 SHALL have port clk_12M, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port btn_up_n, input, 1 bit: raw pushbutton pad, active-low, asynchronous to clk_12M.
REQ-007 SHALL have port btn_dn_n, input, 1 bit: raw pushbutton pad, active-low, asynchronous to clk_12M.
REQ-008 SHALL have port mode, input, 1 bit: synchronous level; 0 = manual step, 1 = auto count.
REQ-009 SHALL have port led, output, WIDTH bits: current count value, registered.
REQ-010 SHALL have port tick, output, 1 bit: one-cycle pulse at each auto-count period, registered.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse on each count roll-over, registered.

Function
REQ-012 SHALL invert each raw button and pass it through a 2-flop synchronizer; the synchronized value (s2) reflects the pad 2 cycles after sampling.
REQ-013 SHALL keep one debounce counter and one stable bit per button:
- s2 equal to stable: the debounce counter clears.
- s2 differs from stable: the debounce counter increments.
- s2 differs and the counter equals DB_CYCLES-1: stable takes s2 and the counter clears.
REQ-014 SHALL raise the press pulse (up_p or dn_p), registered and one cycle wide, on each stable 0->1 transition only; release generates no event.
REQ-015 SHALL implement tick_cnt as a free-running counter 0..TICK_CYCLES-1 while mode=1; tick=1 for the single cycle after tick_cnt equals TICK_CYCLES-1, when tick_cnt returns to 0.
REQ-016 SHALL hold tick_cnt at 0 with tick=0 while mode=0, so that entering mode 1 starts a full period.
REQ-017 SHALL, in manual mode (mode=0), behave as follows:
- up_p alone: led+1.
- dn_p alone: led-1.
- up_p and dn_p in the same cycle: no change and no wrap.
REQ-018 SHALL, in auto mode (mode=1), keep a run flag and a dir flag:
- up_p toggles run.
- dn_p toggles dir (0 = up, 1 = down).
- A tick with run=1 steps led by +1 or -1 per dir.
- Simultaneous up_p and dn_p apply both toggles.
- A tick in the same cycle as those toggles steps using the pre-toggle run and dir.
REQ-019 SHALL keep run and dir unchanged across mode changes; manual mode ignores them.
REQ-020 SHALL perform count arithmetic modulo 2^WIDTH:
- Increment from all-ones gives 0 and wrap=1 for one cycle.
- Decrement from 0 gives all-ones and wrap=1 for one cycle.
- Otherwise wrap=0.
REQ-021 SHALL update led and wrap one cycle after the causing up_p, dn_p or tick pulse.
REQ-022 SHALL meet this total manual-mode latency: with the pad asserted and stable from sampling edge 0, led changes on edge DB_CYCLES+4.
REQ-023 SHALL ignore pad glitches shorter than DB_CYCLES cycles at s2: no press pulse and no led change.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, force to 0: led, tick, wrap, tick_cnt, both debounce counters, both synchronizers and both stable bits (i.e. released), up_p, dn_p and dir; run SHALL go to 1.
REQ-025 SHALL let rst override every simultaneous event in that cycle; a reset mid-debounce discards the partial count.
REQ-026 SHALL NOT generate any press pulse for a button still held when rst deasserts; the held button's stable bit first goes 1 after DB_CYCLES cycles and then does produce a press.

Verification (bench parameters: WIDTH=4, DB_CYCLES=4, TICK_CYCLES=8)
REQ-027 SHALL check: manual mode, btn_up_n low from edge 0 and held -> led 0->1 at edge 8; no further change while held.
REQ-028 SHALL check: manual mode, btn_up_n low for 3 cycles, then high -> led stays 0 and wrap stays 0.
REQ-029 SHALL check: manual mode, led=0, debounced dn press -> led=15 with wrap=1 for exactly one cycle; from led=15, up press -> led=0 with wrap=1.
REQ-030 SHALL check: mode=1 from reset -> tick every 8 cycles and led increments 1,2,3... one cycle after each tick; dn press -> led decrements on the following ticks; up press -> led frozen while tick continues.
REQ-031 SHALL check: manual mode, both buttons pressed on the same edge -> led unchanged and wrap=0.
REQ-032 SHALL check: rst asserted for 1 cycle mid-count (led=9, mode=1) -> next cycle led=0, tick=0, wrap=0; the next tick comes 8 cycles after rst deasserts and gives led=1.
